// File: rtl/fc_layer_seq.sv
// Sequential dense layer: one shared signed MAC computes OUT_LEN dot
// products plus bias, with optional ReLU at write-back.
module fc_layer_seq #(
    parameter int BITWIDTH = 32,
    parameter int IN_LEN   = 25,
    parameter int OUT_LEN  = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              relu_en,
    input  logic [BITWIDTH*IN_LEN-1:0]        data,
    input  logic [BITWIDTH*IN_LEN*OUT_LEN-1:0] weight,
    input  logic [BITWIDTH*OUT_LEN-1:0]       bias,
    output logic                              busy,
    output logic                              done,
    output logic [2*BITWIDTH*OUT_LEN-1:0]     result
);

    localparam int PW = 2 * BITWIDTH;
    localparam int IW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int OW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           acc_q;
    logic [IW-1:0]           i_q;
    logic [OW-1:0]           o_q;
    logic                    relu_q;
    logic                    busy_q;
    logic                    done_q;
    logic [PW*OUT_LEN-1:0]   result_q;

    logic [BITWIDTH-1:0]     d_sel;
    logic [BITWIDTH-1:0]     w_sel;
    logic [BITWIDTH-1:0]     b_sel;
    logic [OW-1:0]           b_idx;
    logic [PW-1:0]           prod;
    logic [PW-1:0]           acc_d;
    logic [PW-1:0]           bias_ext;
    logic [PW-1:0]           wb_d;

    // Operand selection; bias index points at the next output to start.
    always_comb begin
        d_sel = '0;
        w_sel = '0;
        b_sel = '0;
        b_idx = (state_q == IDLE) ? '0 : o_q + 1'b1;
        for (int k = 0; k < IN_LEN; k++) begin
            if (i_q == IW'(k)) begin
                d_sel = data[k*BITWIDTH +: BITWIDTH];
            end
        end
        for (int o = 0; o < OUT_LEN; o++) begin
            for (int k = 0; k < IN_LEN; k++) begin
                if (o_q == OW'(o) && i_q == IW'(k)) begin
                    w_sel = weight[(o*IN_LEN+k)*BITWIDTH +: BITWIDTH];
                end
            end
        end
        for (int k = 0; k < OUT_LEN; k++) begin
            if (b_idx == OW'(k)) begin
                b_sel = bias[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Sign-extended operands make the truncated product the exact signed one.
    assign prod = {{BITWIDTH{d_sel[BITWIDTH-1]}}, d_sel}
                * {{BITWIDTH{w_sel[BITWIDTH-1]}}, w_sel};
    assign acc_d    = acc_q + prod;
    assign bias_ext = {{BITWIDTH{b_sel[BITWIDTH-1]}}, b_sel};
    assign wb_d     = (relu_q && acc_q[PW-1]) ? '0 : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            i_q      <= '0;
            o_q      <= '0;
            relu_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= bias_ext;
                        i_q     <= '0;
                        o_q     <= '0;
                        relu_q  <= relu_en;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (i_q == IW'(IN_LEN - 1)) begin
                        i_q     <= '0;
                        state_q <= STORE;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                STORE: begin
                    for (int k = 0; k < OUT_LEN; k++) begin
                        if (o_q == OW'(k)) begin
                            result_q[k*PW +: PW] <= wb_d;
                        end
                    end
                    if (o_q != OW'(OUT_LEN - 1)) begin
                        o_q     <= o_q + 1'b1;
                        acc_q   <= bias_ext;
                        state_q <= MAC;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: 8-bit, 3x2 main instance plus a
// 1x3 instance for the degenerate input length.
module tb_fc_layer_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        relu_en;
    logic [23:0] data;
    logic [47:0] weight;
    logic [15:0] bias;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        start2;
    logic [7:0]  data2;
    logic [23:0] weight2;
    logic [23:0] bias2;
    logic        busy2;
    logic        done2;
    logic [47:0] result2;

    int n_assert = 0;
    int n_fail   = 0;

    fc_layer_seq #(.BITWIDTH(8), .IN_LEN(3), .OUT_LEN(2)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .relu_en (relu_en),
        .data    (data),
        .weight  (weight),
        .bias    (bias),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    fc_layer_seq #(.BITWIDTH(8), .IN_LEN(1), .OUT_LEN(3)) u_deg (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .relu_en (1'b0),
        .data    (data2),
        .weight  (weight2),
        .bias    (bias2),
        .busy    (busy2),
        .done    (done2),
        .result  (result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_basic();
        data   = {8'd3, 8'd2, 8'd1};
        weight = {8'hFF, 8'h00, 8'h02, 8'h01, 8'h01, 8'h01};
        bias   = {8'hFB, 8'h0A};
    endtask

    // Start, check busy/done per cycle, flip relu_en mid-run; ends in done cycle.
    task automatic do_run(input logic r, input string tag);
        @(negedge clk);
        start   = 1'b1;
        relu_en = r;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk({tag, "_busy"}, {busy, done}, 2'b10);
            if (k == 3) relu_en = ~relu_en;
            @(negedge clk);
        end
        chk({tag, "_done"}, {busy, done}, 2'b01);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        relu_en = 1'b0;
        start2  = 1'b0;
        data2   = '0;
        weight2 = '0;
        bias2   = '0;
        set_basic();
        repeat (3) @(negedge clk);
        chk("rst_bd", {busy, done}, 2'b00);
        chk("rst_res", result, 32'h0);
        chk("rst_res2", result2, 48'h0);
        rst = 1'b0;

        // Basic run with per-output visibility timing
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("basic_busy", {busy, done}, 2'b10);
            if (k == 4) chk("basic_r0_early", result[15:0], 16'h0000);
            if (k == 5) chk("basic_r0_vis", result, 32'h0000_0010);
            @(negedge clk);
        end
        chk("basic_done", {busy, done}, 2'b01);
        chk("basic_res", result, 32'hFFFA_0010);
        @(negedge clk);
        chk("basic_after", {busy, done}, 2'b00);

        // ReLU, captured at start; do_run toggles relu_en mid-run
        do_run(1'b1, "relu");
        chk("relu_res", result, 32'h0000_0010);

        // Wrap-around without saturation
        data   = {3{8'h80}};
        weight = {6{8'h80}};
        bias   = {2{8'h7F}};
        do_run(1'b0, "wrap");
        chk("wrap_res", result, 32'hC07F_C07F);

        // start held high through the run, then accepted in the done cycle
        set_basic();
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            chk("hold_busy", {busy, done}, 2'b10);
            @(negedge clk);
        end
        chk("hold_done", {busy, done}, 2'b01);
        chk("hold_res", result, 32'hFFFA_0010);
        relu_en = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        relu_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("b2b_busy", {busy, done}, 2'b10);
            @(negedge clk);
        end
        chk("b2b_done", {busy, done}, 2'b01);
        chk("b2b_res", result, 32'h0000_0010);

        // Reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_bd", {busy, done}, 2'b00);
        chk("midrst_res", result, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_nodone", {busy, done}, 2'b00);
        end

        // Reset wins over a coincident start
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_bd", {busy, done}, 2'b00);
        @(negedge clk);
        chk("rststart_bd2", {busy, done}, 2'b00);

        do_run(1'b0, "post_rst");
        chk("post_rst_res", result, 32'hFFFA_0010);

        // Degenerate IN_LEN=1, OUT_LEN=3: N=6, done at T0+7
        data2   = 8'd5;
        weight2 = {8'h03, 8'hFF, 8'h01};
        bias2   = {8'hEC, 8'h00, 8'h00};
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("deg_busy", {busy2, done2}, 2'b10);
            @(negedge clk);
        end
        chk("deg_done", {busy2, done2}, 2'b01);
        chk("deg_res", result2, 48'hFFFB_FFFB_0005);
        @(negedge clk);
        chk("deg_after", {busy2, done2}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Time-multiplexed, parametrised fully-connected (dense) layer for the LeNet NPU datapath. It computes OUT_LEN dot products of an IN_LEN-element signed input vector against a flat weight matrix, plus per-output bias. The work runs on a single shared signed multiply-accumulate unit under a start/busy/done handshake, and an optional ReLU is applied at write-back. It replaces the fully parallel combinational FC stage wherever area matters more than latency.

## Interface
- BITWIDTH, 32, width of each signed data, weight and bias element
- IN_LEN, 25, input vector length (≥1)
- OUT_LEN, 10, number of outputs (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a computation; sampled only in IDLE
- relu_en  in  1  mode select, captured at the accepted start: 1 = clamp negative results to 0
- data  in  BITWIDTH*IN_LEN  element i at [i*BITWIDTH +: BITWIDTH]
- weight  in  BITWIDTH*IN_LEN*OUT_LEN  element (o,i) at [(o*IN_LEN+i)*BITWIDTH +: BITWIDTH]
- bias  in  BITWIDTH*OUT_LEN  element o at [o*BITWIDTH +: BITWIDTH]
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when all results are written
- result  out  2*BITWIDTH*OUT_LEN  registered; output o at [o*2*BITWIDTH +: 2*BITWIDTH]

## Operation
- The block does not capture `data`, `weight` or `bias`. Inputs must stay stable from the start edge until `done`.
- FSM states: IDLE, MAC, STORE.
- **IDLE + start:**
  - acc ← sign-extended bias[0]; o ← 0; i ← 0.
  - Latch relu_en.
  - Go to MAC.
- **MAC:**
  - acc ← acc + data[i]*weight[o][i].
  - i increments each cycle.
  - When i == IN_LEN-1, clear i and go to STORE.
- **STORE:**
  - result[o] ← (relu && acc[MSB]) ? 0 : acc.
  - If o < OUT_LEN-1: o increments, acc ← sign-extended bias[o+1], go to MAC.
  - Else go to IDLE and pulse done.
- **Arithmetic:**
  - Operands are signed two's complement.
  - Each product is the full 2*BITWIDTH signed product.
  - The accumulator is 2*BITWIDTH and wraps modulo 2^(2*BITWIDTH); there is no saturation.
  - Bias is sign-extended to 2*BITWIDTH.
- `start` while busy is ignored. `start` during the `done` cycle is accepted (the FSM is in IDLE).
- `result` words for outputs not yet reached keep their previous values. The full vector is valid only from `done` until the next accepted start.
- `rst`:
  - state ← IDLE; busy ← 0; done ← 0; result ← 0; acc, i, o ← 0.
  - Mid-operation reset aborts the run and no `done` is produced.
  - rst has priority over a coincident start.

## Timing
- Start is accepted at edge T0.
- busy is high in cycles T0+1 … T0+N, where N = OUT_LEN*(IN_LEN+1).
- done is high exactly in cycle T0+N+1, with busy low in that cycle.
- result[o] becomes visible after edge T0 + (o+1)*(IN_LEN+1).
- Throughput: one new start every N+1 cycles (back-to-back via start-on-done).
- Reset values: busy=0, done=0, result=0.

## Test plan
All tests use BITWIDTH=8, IN_LEN=3, OUT_LEN=2 (N=8) unless stated.
- **Basic dot products.** data=(1,2,3); w0=(1,1,1), w1=(2,0,-1); bias=(10,-5); relu_en=0.
  - result0 = 16 (0x0010), result1 = -6 (0xFFFA).
  - busy is high for 8 cycles; done pulses in cycle T0+9.
- **ReLU mode.** Same stimulus with relu_en=1.
  - result0 = 16, result1 = 0x0000.
  - Toggling relu_en mid-run has no effect.
- **Wrap-around.** All data and all weights = -128; bias = 127.
  - Each result = 3*16384+127 mod 2^16 = 0xC07F (-16257), with no saturation.
- **Handshake.**
  - start held high for the whole run is ignored while busy; done timing is unchanged.
  - start asserted in the done cycle begins a second run whose done arrives 9 cycles later, with correct results.
- **Reset mid-run.** rst is asserted at T0+4.
  - Next cycle: busy=0, result=0, and no done follows.
  - A subsequent start completes normally.
  - rst coincident with start is not accepted.
- **Degenerate length.** IN_LEN=1, OUT_LEN=3, data=(5), weights=(1,-1,3), bias=(0,0,-20).
  - results = 5, -5, -5.
  - done in cycle T0+7.
